// File: rtl/audio_pcie_pkg.sv
// Shared types and constants for the audio-to-PCIe burst reader.
// Holds the FSM encoding and the default widths/burst size.
package audio_pcie_pkg;

    localparam int DATA_W_DEF    = 128;
    localparam int LVL_W_DEF     = 11;
    localparam int BURST_LEN_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // Burst size in bytes as reported to the DMA engine.
    function automatic logic [15:0] burst_bytes(input int len, input int w);
        return 16'(len * w / 8);
    endfunction

    localparam logic [15:0] BURST_BYTES = burst_bytes(BURST_LEN_DEF, DATA_W_DEF);

endpackage

// File: rtl/audio_pcie_skid2.sv
// Two-entry FIFO that absorbs the one-cycle FIFO read latency.
// Pointers and count are reset; the data storage is not.
module audio_pcie_skid2
    import audio_pcie_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    // Pointer and occupancy tracking; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            if (i_push && !i_pop)      r_count <= r_count + 2'd1;
            else if (!i_push && i_pop) r_count <= r_count - 2'd1;
        end
    end

    // Data storage written at the tail; no reset needed.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/audio_pcie_burst_reader.sv
// Drains fixed-size bursts from the audio FIFO into a valid/ready stream.
// Requests a DMA slot once a full burst is buffered, then streams it.
module audio_pcie_burst_reader
    import audio_pcie_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LVL_W     = LVL_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    input  logic [LVL_W-1:0]  fifo_rd_level,
    output logic              dma_req,
    input  logic              dma_ack,
    output logic [15:0]       dma_len,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [CNT_W-1:0]  burst_cnt,
    output logic              underrun_err
);

    localparam int BC_W = $clog2(BURST_LEN + 1);
    localparam logic [BC_W-1:0]  LEN_C    = BC_W'(BURST_LEN);
    localparam logic [BC_W-1:0]  LAST_C   = BC_W'(BURST_LEN - 1);
    localparam logic [LVL_W-1:0] LVL_TRIG = LVL_W'(BURST_LEN);

    state_t           r_state;
    logic [BC_W-1:0]  r_issued;
    logic [BC_W-1:0]  r_sent;
    logic             r_inflight;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_underrun;

    logic [1:0]       w_count;
    logic             w_valid;
    logic             w_pop;
    logic             w_last;
    logic             w_room;
    logic             w_rd_en;

    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid && m_tready;
    assign w_last  = w_valid && (r_sent == LAST_C);

    // Words held after this cycle (buffered + in flight - leaving) stay <= 2.
    assign w_room  = ({1'b0, w_count} + {2'b0, r_inflight}
                      - {2'b0, w_pop}) < 3'd2;

    assign w_rd_en = !rst && (r_state == ST_XFER) && (r_issued < LEN_C)
                     && !fifo_rd_empty && w_room;

    audio_pcie_skid2 #(
        .W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_din   (fifo_rd_data),
        .i_pop   (w_pop),
        .o_dout  (m_tdata),
        .o_count (w_count)
    );

    // Burst FSM with read/beat counters, completion count and underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_issued    <= '0;
            r_sent      <= '0;
            r_inflight  <= 1'b0;
            r_burst_cnt <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            unique case (r_state)
                ST_IDLE: begin
                    if (enable && fifo_rd_level >= LVL_TRIG)
                        r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (dma_ack) begin
                        r_state  <= ST_XFER;
                        r_issued <= '0;
                        r_sent   <= '0;
                    end
                end
                ST_XFER: begin
                    if (w_rd_en) r_issued <= r_issued + BC_W'(1);
                    if (w_pop)   r_sent   <= r_sent + BC_W'(1);
                    if (w_pop && w_last) begin
                        r_state     <= ST_IDLE;
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                    end
                    if (fifo_rd_empty && r_issued < LEN_C)
                        r_underrun <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_rd_en   = w_rd_en;
    assign dma_req      = (r_state == ST_REQ);
    assign dma_len      = burst_bytes(BURST_LEN, DATA_W);
    assign m_tvalid     = w_valid;
    assign m_tlast      = w_last;
    assign burst_cnt    = r_burst_cnt;
    assign underrun_err = r_underrun;

endmodule

// File: tb/tb_audio_pcie_burst_reader.sv
// Bench for audio_pcie_burst_reader: FIFO model, random data,
// word-order scoreboard and per-scenario checks.
module tb_audio_pcie_burst_reader;

    localparam int DW = 128;
    localparam int LW = 11;
    localparam int BL = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic [LW-1:0] fifo_rd_level;
    logic          dma_req;
    logic          dma_ack;
    logic [15:0]   dma_len;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [CW-1:0] burst_cnt;
    logic          underrun_err;

    always #5 clk = ~clk;

    audio_pcie_burst_reader #(
        .DATA_W    (DW),
        .LVL_W     (LW),
        .BURST_LEN (BL),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_level (fifo_rd_level),
        .dma_req       (dma_req),
        .dma_ack       (dma_ack),
        .dma_len       (dma_len),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .burst_cnt     (burst_cnt),
        .underrun_err  (underrun_err)
    );

    // Behavioural source FIFO: word array, write/read indices.
    logic [DW-1:0] fmem [0:1023];
    int f_wr = 0;
    int f_rd = 0;
    bit force_empty = 1'b0;

    assign fifo_rd_level = LW'(f_wr - f_rd);
    assign fifo_rd_empty = force_empty || (f_wr == f_rd);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fmem[f_rd % 1024];
            f_rd <= f_rd + 1;
        end
    end

    int total = 0;
    int bad = 0;
    int exp_idx = 0;
    int exp_bursts = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            fmem[f_wr % 1024] = {$urandom(), $urandom(), $urandom(), $urandom()};
            f_wr++;
        end
        #1;
    endtask

    task automatic wait_req(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (dma_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_ack(input int dly);
        repeat (dly) tick();
        dma_ack = 1'b1;
        tick();
        dma_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        dma_ack = 1'b0;
        m_tready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({fifo_rd_en, dma_req, m_tvalid, m_tlast, underrun_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outs got=%b exp=00000",
                     {fifo_rd_en, dma_req, m_tvalid, m_tlast, underrun_err});
        end
        total++;
        if (burst_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d exp=0", burst_cnt);
        end
        total++;
        if (dma_len !== 16'(BL * DW / 8)) begin
            bad++;
            $display("FAIL dma_len got=%0d exp=%0d", dma_len, BL * DW / 8);
        end
        dma_ack = 1'b1;
        tick();
        dma_ack = 1'b0;
        tick();
        total++;
        if (dma_req !== 1'b0 || m_tvalid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL stray_ack got=%b%b%b exp=000", dma_req, m_tvalid, fifo_rd_en);
        end
    endtask

    task automatic test_request();
        int req_seen;
        int rd_seen;
        req_seen = 0;
        rd_seen = 0;
        enable = 1'b1;
        preload(BL - 1);
        repeat (4) begin
            tick();
            if (dma_req) req_seen++;
        end
        total++;
        if (req_seen != 0) begin
            bad++;
            $display("FAIL req_below_level got=%0d exp=0", req_seen);
        end
        preload(1);
        total++;
        if (dma_req !== 1'b0) begin
            bad++;
            $display("FAIL req_early got=%b exp=0", dma_req);
        end
        tick();
        total++;
        if (dma_req !== 1'b1) begin
            bad++;
            $display("FAIL req_rise got=%b exp=1", dma_req);
        end
        repeat (5) begin
            if (fifo_rd_en) rd_seen++;
            tick();
        end
        total++;
        if (rd_seen != 0 || dma_req !== 1'b1) begin
            bad++;
            $display("FAIL read_before_ack got=%0d/%b exp=0/1", rd_seen, dma_req);
        end
    endtask

    task automatic test_stream();
        int beats;
        int rds;
        int cyc;
        pulse_ack(0);
        exp_bursts++;
        beats = 0;
        rds = 0;
        cyc = 0;
        while (beats < BL && cyc < 200) begin
            m_tready = 1'b1;
            #1;
            if (cyc < 3) begin
                total++;
                if (m_tvalid !== (cyc == 2)) begin
                    bad++;
                    $display("FAIL first_beat_lat cyc=%0d got=%b exp=%b",
                             cyc, m_tvalid, cyc == 2);
                end
            end
            if (cyc >= 2 && cyc < BL + 2) begin
                total++;
                if (m_tvalid !== 1'b1) begin
                    bad++;
                    $display("FAIL throughput cyc=%0d got=0 exp=1", cyc);
                end
            end
            if (fifo_rd_en) rds++;
            if (m_tvalid && m_tready) begin
                total++;
                if (m_tdata !== fmem[exp_idx % 1024] || m_tlast !== (beats == BL - 1)) begin
                    bad++;
                    $display("FAIL stream_beat%0d got=%h/%b exp=%h/%b", beats, m_tdata,
                             m_tlast, fmem[exp_idx % 1024], beats == BL - 1);
                end
                exp_idx++;
                beats++;
            end
            cyc++;
            tick();
        end
        total++;
        if (beats != BL || burst_cnt !== CW'(exp_bursts) || m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL stream_end got=%0d/%0d/%b exp=%0d/%0d/0",
                     beats, burst_cnt, m_tvalid, BL, exp_bursts);
        end
        total++;
        if (underrun_err !== 1'b0) begin
            bad++;
            $display("FAIL no_underrun got=1 exp=0");
        end
    endtask

    task automatic test_backpressure();
        int beats;
        int rds;
        int cyc;
        bit ok;
        bit stalled;
        logic [DW-1:0] held;
        preload(BL);
        wait_req(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_req got=0 exp=1");
        end
        pulse_ack(2);
        exp_bursts++;
        beats = 0;
        rds = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (beats < BL && cyc < 400) begin
            m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            #1;
            if (stalled) begin
                total++;
                if (m_tvalid !== 1'b1 || m_tdata !== held) begin
                    bad++;
                    $display("FAIL stall_hold got=%b/%h exp=1/%h", m_tvalid, m_tdata, held);
                end
            end
            if (fifo_rd_en) rds++;
            if (m_tvalid && m_tready) begin
                total++;
                if (m_tdata !== fmem[exp_idx % 1024] || m_tlast !== (beats == BL - 1)) begin
                    bad++;
                    $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", beats, m_tdata,
                             m_tlast, fmem[exp_idx % 1024], beats == BL - 1);
                end
                exp_idx++;
                beats++;
            end
            total++;
            if (rds - beats > 2) begin
                bad++;
                $display("FAIL outstanding got=%0d exp<=2", rds - beats);
            end
            stalled = m_tvalid && !m_tready;
            held = m_tdata;
            cyc++;
            tick();
        end
        total++;
        if (beats != BL || rds != BL || burst_cnt !== CW'(exp_bursts)) begin
            bad++;
            $display("FAIL bp_end got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     beats, rds, burst_cnt, BL, BL, exp_bursts);
        end
    endtask

    task automatic test_underrun();
        int beats;
        int rds;
        int cyc;
        int emp_left;
        bit fired;
        bit ok;
        preload(BL);
        wait_req(20, ok);
        total++;
        if (!ok || underrun_err !== 1'b0) begin
            bad++;
            $display("FAIL ur_pre got=%b/%b exp=1/0", ok, underrun_err);
        end
        pulse_ack(1);
        exp_bursts++;
        beats = 0;
        rds = 0;
        cyc = 0;
        emp_left = 0;
        fired = 1'b0;
        while (beats < BL && cyc < 300) begin
            if (emp_left > 0) begin
                force_empty = 1'b1;
                emp_left--;
            end else begin
                force_empty = 1'b0;
            end
            if (rds == 10 && !fired) begin
                fired = 1'b1;
                force_empty = 1'b1;
                emp_left = 3;
            end
            m_tready = 1'b1;
            #1;
            if (fifo_rd_en) rds++;
            if (m_tvalid && m_tready) begin
                total++;
                if (m_tdata !== fmem[exp_idx % 1024] || m_tlast !== (beats == BL - 1)) begin
                    bad++;
                    $display("FAIL ur_beat%0d got=%h/%b exp=%h/%b", beats, m_tdata,
                             m_tlast, fmem[exp_idx % 1024], beats == BL - 1);
                end
                exp_idx++;
                beats++;
            end
            cyc++;
            tick();
        end
        force_empty = 1'b0;
        total++;
        if (beats != BL || underrun_err !== 1'b1 || burst_cnt !== CW'(exp_bursts)) begin
            bad++;
            $display("FAIL ur_end got=%0d/%b/%0d exp=%0d/1/%0d",
                     beats, underrun_err, burst_cnt, BL, exp_bursts);
        end
        repeat (3) tick();
        total++;
        if (underrun_err !== 1'b1) begin
            bad++;
            $display("FAIL ur_sticky got=0 exp=1");
        end
    endtask

    task automatic test_enable_drop();
        int beats;
        int cyc;
        int req_seen;
        bit ok;
        preload(2 * BL);
        wait_req(20, ok);
        pulse_ack(0);
        exp_bursts++;
        beats = 0;
        cyc = 0;
        while (beats < BL && cyc < 300) begin
            if (beats == 5) enable = 1'b0;
            m_tready = ($urandom_range(0, 3) != 0);
            #1;
            if (m_tvalid && m_tready) begin
                total++;
                if (m_tdata !== fmem[exp_idx % 1024] || m_tlast !== (beats == BL - 1)) begin
                    bad++;
                    $display("FAIL en_beat%0d got=%h/%b exp=%h/%b", beats, m_tdata,
                             m_tlast, fmem[exp_idx % 1024], beats == BL - 1);
                end
                exp_idx++;
                beats++;
            end
            cyc++;
            tick();
        end
        total++;
        if (!ok || beats != BL || burst_cnt !== CW'(exp_bursts)) begin
            bad++;
            $display("FAIL en_burst got=%b/%0d/%0d exp=1/%0d/%0d",
                     ok, beats, burst_cnt, BL, exp_bursts);
        end
        req_seen = 0;
        repeat (6) begin
            tick();
            if (dma_req || fifo_rd_en) req_seen++;
        end
        total++;
        if (req_seen != 0) begin
            bad++;
            $display("FAIL en_idle got=%0d exp=0", req_seen);
        end
        enable = 1'b1;
        wait_req(5, ok);
        pulse_ack(3);
        exp_bursts++;
        beats = 0;
        cyc = 0;
        while (beats < BL && cyc < 200) begin
            m_tready = 1'b1;
            #1;
            if (m_tvalid && m_tready) begin
                total++;
                if (m_tdata !== fmem[exp_idx % 1024]) begin
                    bad++;
                    $display("FAIL en2_beat%0d got=%h exp=%h",
                             beats, m_tdata, fmem[exp_idx % 1024]);
                end
                exp_idx++;
                beats++;
            end
            cyc++;
            tick();
        end
        total++;
        if (!ok || beats != BL || burst_cnt !== CW'(exp_bursts)) begin
            bad++;
            $display("FAIL en_resume got=%b/%0d/%0d exp=1/%0d/%0d",
                     ok, beats, burst_cnt, BL, exp_bursts);
        end
    endtask

    task automatic test_reset_mid_burst();
        int beats;
        int cyc;
        bit ok;
        preload(2 * BL);
        wait_req(20, ok);
        pulse_ack(1);
        beats = 0;
        cyc = 0;
        while (beats < 12 && cyc < 100) begin
            m_tready = 1'b1;
            #1;
            if (m_tvalid && m_tready) begin
                exp_idx++;
                beats++;
            end
            cyc++;
            tick();
        end
        rst = 1'b1;
        m_tready = 1'b0;
        tick();
        total++;
        if ({fifo_rd_en, dma_req, m_tvalid, m_tlast, underrun_err} !== 5'b0
            || burst_cnt !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid got=%b/%0d exp=00000/0",
                     {fifo_rd_en, dma_req, m_tvalid, m_tlast, underrun_err}, burst_cnt);
        end
        rst = 1'b0;
        exp_bursts = 0;
        exp_idx = f_rd;
        wait_req(10, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_rereq got=0 exp=1");
        end
        pulse_ack(0);
        exp_bursts++;
        beats = 0;
        cyc = 0;
        while (beats < BL && cyc < 200) begin
            m_tready = 1'b1;
            #1;
            if (m_tvalid && m_tready) begin
                total++;
                if (m_tdata !== fmem[exp_idx % 1024] || m_tlast !== (beats == BL - 1)) begin
                    bad++;
                    $display("FAIL rst_beat%0d got=%h/%b exp=%h/%b", beats, m_tdata,
                             m_tlast, fmem[exp_idx % 1024], beats == BL - 1);
                end
                exp_idx++;
                beats++;
            end
            cyc++;
            tick();
        end
        total++;
        if (beats != BL || burst_cnt !== CW'(exp_bursts)) begin
            bad++;
            $display("FAIL rst_burst got=%0d/%0d exp=%0d/%0d",
                     beats, burst_cnt, BL, exp_bursts);
        end
    endtask

    task automatic test_random_bursts();
        int beats;
        int rds;
        int cyc;
        bit ok;
        for (int b = 0; b < 3; b++) begin
            preload(BL);
            wait_req(20, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rnd_req%0d got=0 exp=1", b);
            end
            pulse_ack($urandom_range(0, 6));
            exp_bursts++;
            beats = 0;
            rds = 0;
            cyc = 0;
            while (beats < BL && cyc < 400) begin
                m_tready = ($urandom_range(0, 2) != 0);
                #1;
                if (fifo_rd_en) rds++;
                if (m_tvalid && m_tready) begin
                    total++;
                    if (m_tdata !== fmem[exp_idx % 1024]
                        || m_tlast !== (beats == BL - 1)) begin
                        bad++;
                        $display("FAIL rnd_beat%0d got=%h/%b exp=%h/%b", beats, m_tdata,
                                 m_tlast, fmem[exp_idx % 1024], beats == BL - 1);
                    end
                    exp_idx++;
                    beats++;
                end
                if (rds - beats > 2) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_outstanding got=%0d exp<=2", rds - beats);
                end
                cyc++;
                tick();
            end
            total++;
            if (beats != BL || burst_cnt !== CW'(exp_bursts)) begin
                bad++;
                $display("FAIL rnd_end%0d got=%0d/%0d exp=%0d/%0d",
                         b, beats, burst_cnt, BL, exp_bursts);
            end
        end
    endtask

    initial begin
        dma_ack = 1'b0;
        m_tready = 1'b0;
        enable = 1'b0;
        rst = 1'b1;
        test_reset();
        test_request();
        test_stream();
        test_backpressure();
        test_underrun();
        test_enable_drop();
        test_reset_mid_burst();
        test_random_bursts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
